rr_grant_ctrl: RTL and testbench
================================

# rr_grant_ctrl

Round-robin arbiter that shares the registered 3-to-8 one-hot decoder between eight requesters. It grants the decoder to one requester at a time for a bounded slot. It drives the decoder's 3-bit select with the granted index and presents a matching one-hot grant vector. Fairness comes from a rotating priority pointer, so no requester waits more than seven slots while it keeps its request asserted.

## Interface
- HOLD_CYCLES, 4, maximum slot length in cycles (legal range 1–15); held in a 4-bit counter.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low; sampled on posedge clk.
- enable  input  1  arbitration enable; new grants are issued only while high.
- req  input  8  per-requester request; bit i belongs to requester i.
- release_i  input  1  early release of the current slot by the grant holder.
- sel  output  3  granted index, wired to the decoder select.
- sel_valid  output  1  high while sel carries a live grant.
- grant  output  8  one-hot grant, equal to 1<<sel while sel_valid, else 8'h00.
- busy  output  1  high while in GRANT state.

## Operation
- State machine has two states.
  - IDLE:
    - If enable=1 and req!=0, select the first set req bit searching circularly from ptr+1 (ptr+1, ptr+2, …, ptr, mod 8).
    - Register the winner into sel, set grant=1<<winner, sel_valid=1, busy=1.
    - Load cnt=HOLD_CYCLES-1 and go to GRANT.
    - Otherwise remain in IDLE with all outputs low.
  - GRANT: the slot ends on the first edge where any of the following holds:
    - cnt==0;
    - release_i=1;
    - req[sel]==0.
  - Slot end actions, in order:
    - ptr<=sel;
    - grant<=0, sel_valid<=0, busy<=0;
    - go to IDLE.
  - Otherwise cnt<=cnt-1 and the grant is held.
- ptr is internal, 3 bits, and wraps 7→0.
- enable is consulted only in IDLE. Dropping enable during GRANT does not abort the slot.
- sel holds its last value after a slot ends; only sel_valid and grant clear. Consumers must qualify sel with sel_valid.
- A req change on a non-granted bit during GRANT has no effect until the next IDLE cycle.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Reset (rst=0 at an edge) sets:
  - state=IDLE;
  - sel=3'd0, sel_valid=0, grant=8'h00, busy=0;
  - cnt=0;
  - ptr=3'd7, so the first search starts at requester 0.
- Reset applies mid-slot and overrides release_i and req. Outputs are zero the edge after rst is sampled low.
- Grant latency: a request sampled in IDLE at edge t produces grant/sel_valid high after edge t.
- Slot length:
  - With the request held and no release, the grant is high for exactly HOLD_CYCLES cycles.
  - release_i or req[sel] sampled low at edge t drops the grant after edge t; the cycle before edge t still counts as granted.
- There is a mandatory one-cycle IDLE gap between consecutive grants, even to different requesters. Worst-case grant period is HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1 gives a 1-cycle grant followed by a 1-cycle gap.
- Simultaneous release_i=1 and cnt==0 produce a single slot end; there is no double-advance of ptr.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=8'hFF. Required: grant=8'h00, sel=0, sel_valid=0, busy=0. The first grant after rst=1 is 8'h01.
- Single requester, HOLD_CYCLES=4: req=8'h08 held, enable=1. Required: grant=8'h08 and sel=3 for 4 cycles, then 1 cycle of 8'h00, repeating.
- Full load: req=8'hFF held. Required: grant sequence 01,02,04,08,10,20,40,80,01, each for 4 cycles separated by 1 idle cycle. sel follows 0..7 and wraps.
- Early release and drop:
  - req=8'h20; release_i pulsed on the 2nd grant cycle. Required: grant 8'h20 for 2 cycles only.
  - Repeat with req[5] dropped instead of release_i. Required: the same 2-cycle grant.
- Fairness after release:
  - After requester 5 is granted, set req=8'h21. Required: next grant 8'h01 (search starts at 6 and wraps), then 8'h20.
  - Set enable=0 mid-slot. Required: the slot completes and no further grant is issued.
- Reset mid-slot: assert rst=0 on the 2nd grant cycle of 8'h04 with req=8'h14. Required:
  - outputs clear after that edge;
  - after rst=1, the first grant is 8'h04 (ptr=7, lowest index wins).

Source files
------------

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin arbiter sharing the registered 3-to-8 decoder
// among eight requesters. One requester at a time holds the decoder for a
// slot of at most HOLD_CYCLES cycles. A rotating priority pointer keeps the
// arbitration fair. Every output is registered.
module rr_grant_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       release_i,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic [7:0] grant,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [2:0] sel_next;
    logic       sel_valid_next;
    logic [7:0] grant_next;
    logic       busy_next;

    logic [2:0] cand;
    logic [2:0] winner;
    logic       found;
    logic       slot_end;

    // Find the first requester searching circularly from ptr+1; ptr itself is checked last.
    always_comb begin
        cand   = ptr;
        winner = ptr;
        found  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // A slot ends on timeout, on early release, or when the holder drops its request.
    always_comb begin
        slot_end = (cnt == 4'd0) || release_i || !req[sel];
    end

    // Next-state and next-output logic for the two-state arbiter.
    always_comb begin
        state_next     = state;
        ptr_next       = ptr;
        cnt_next       = cnt;
        sel_next       = sel;
        sel_valid_next = sel_valid;
        grant_next     = grant;
        busy_next      = busy;
        case (state)
            IDLE: begin
                if (enable && found) begin
                    sel_next       = winner;
                    grant_next     = 8'b1 << winner;
                    sel_valid_next = 1'b1;
                    busy_next      = 1'b1;
                    cnt_next       = HOLD_LOAD;
                    state_next     = GRANT;
                end else begin
                    sel_valid_next = 1'b0;
                    grant_next     = 8'h00;
                    busy_next      = 1'b0;
                end
            end
            GRANT: begin
                if (slot_end) begin
                    ptr_next       = sel;
                    grant_next     = 8'h00;
                    sel_valid_next = 1'b0;
                    busy_next      = 1'b0;
                    state_next     = IDLE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                grant_next     = 8'h00;
                sel_valid_next = 1'b0;
                busy_next      = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    // State and output registers. ptr resets to 7 so the first search starts at requester 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            cnt       <= 4'd0;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            grant     <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            cnt       <= cnt_next;
            sel       <= sel_next;
            sel_valid <= sel_valid_next;
            grant     <= grant_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed bench for the round-robin decoder arbiter.
// A second instance with HOLD_CYCLES=1 shares the stimulus so the shortest slot can be checked.
module tb_rr_grant_ctrl;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] req;
    logic       release_i;
    logic [2:0] sel;
    logic       sel_valid;
    logic [7:0] grant;
    logic       busy;
    logic [2:0] sel1;
    logic       sel_valid1;
    logic [7:0] grant1;
    logic       busy1;

    int checks = 0;
    int errors = 0;

    rr_grant_ctrl #(.HOLD_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .release_i(release_i),
        .sel(sel), .sel_valid(sel_valid), .grant(grant), .busy(busy)
    );

    rr_grant_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .req(req), .release_i(release_i),
        .sel(sel1), .sel_valid(sel_valid1), .grant(grant1), .busy(busy1)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle; inputs changed here are seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return both instances to IDLE with ptr=7.
    task automatic do_reset();
        rst = 1'b0; enable = 1'b0; req = 8'h00; release_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Reset with all requests high, then the first grant goes to requester 0.
    task automatic test_reset();
        rst = 1'b0; req = 8'hFF; enable = 1'b1; release_i = 1'b0;
        tick();
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL reset_grant: got %h expected 00", grant); end
        checks++; if (sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel_valid: got %b expected 0", sel_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1;
        tick();
        checks++; if (grant !== 8'h01) begin errors++; $display("[TB] FAIL reset_first_grant: got %h expected 01", grant); end
        checks++; if (sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_first_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_first_busy: got %b expected 1", busy); end
    endtask

    // One requester held: 4 granted cycles, 1 idle cycle, repeating.
    task automatic test_single();
        logic [7:0] exp_g;
        logic       exp_v;
        do_reset();
        req = 8'h08; enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_v = ((c % 5) < 4);
            exp_g = exp_v ? 8'h08 : 8'h00;
            checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL single_grant c=%0d: got %h expected %h", c, grant, exp_g); end
            checks++; if (sel !== 3'd3) begin errors++; $display("[TB] FAIL single_sel c=%0d: got %0d expected 3", c, sel); end
            checks++; if (sel_valid !== exp_v) begin errors++; $display("[TB] FAIL single_valid c=%0d: got %b expected %b", c, sel_valid, exp_v); end
        end
    endtask

    // All requesters held: grants rotate 0..7 and wrap, sel holds through the gap.
    task automatic test_full_load();
        logic [2:0] exp_s;
        logic [7:0] exp_g;
        logic       exp_b;
        do_reset();
        req = 8'hFF; enable = 1'b1;
        for (int c = 0; c < 45; c++) begin
            tick();
            exp_s = 3'((c / 5) % 8);
            exp_b = ((c % 5) < 4);
            exp_g = exp_b ? (8'h01 << exp_s) : 8'h00;
            checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL full_grant c=%0d: got %h expected %h", c, grant, exp_g); end
            checks++; if (sel !== exp_s) begin errors++; $display("[TB] FAIL full_sel c=%0d: got %0d expected %0d", c, sel, exp_s); end
            checks++; if (busy !== exp_b) begin errors++; $display("[TB] FAIL full_busy c=%0d: got %b expected %b", c, busy, exp_b); end
        end
    endtask

    // Release pulse, then request drop, both on the 2nd grant cycle: 2-cycle grants.
    task automatic test_early_release();
        do_reset();
        req = 8'h20; enable = 1'b1;
        tick();
        checks++; if (grant !== 8'h20) begin errors++; $display("[TB] FAIL rel_c1: got %h expected 20", grant); end
        tick();
        checks++; if (grant !== 8'h20) begin errors++; $display("[TB] FAIL rel_c2: got %h expected 20", grant); end
        release_i = 1'b1;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL rel_drop: got %h expected 00", grant); end
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("[TB] FAIL rel_valid: got %b expected 0", sel_valid); end
        release_i = 1'b0; req = 8'h00;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL rel_idle: got %h expected 00", grant); end

        do_reset();
        req = 8'h20; enable = 1'b1;
        tick();
        checks++; if (grant !== 8'h20) begin errors++; $display("[TB] FAIL drop_c1: got %h expected 20", grant); end
        tick();
        checks++; if (grant !== 8'h20) begin errors++; $display("[TB] FAIL drop_c2: got %h expected 20", grant); end
        req = 8'h00;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL drop_end: got %h expected 00", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_busy: got %b expected 0", busy); end
        checks++; if (sel !== 3'd5) begin errors++; $display("[TB] FAIL drop_sel_hold: got %0d expected 5", sel); end
    endtask

    // After requester 5, req=21 wraps to 0 then back to 5; enable drop lets the slot finish.
    task automatic test_fairness();
        logic [7:0] exp_a [10] = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h20};
        logic [7:0] exp_b [6]  = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00};
        do_reset();
        req = 8'h20; enable = 1'b1;
        tick();
        checks++; if (sel !== 3'd5) begin errors++; $display("[TB] FAIL fair_first_sel: got %0d expected 5", sel); end
        req = 8'h21;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (grant !== exp_a[i]) begin errors++; $display("[TB] FAIL fair_seq i=%0d: got %h expected %h", i, grant, exp_a[i]); end
        end
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (grant !== exp_b[i]) begin errors++; $display("[TB] FAIL fair_disable i=%0d: got %h expected %h", i, grant, exp_b[i]); end
        end
    endtask

    // Reset on the 2nd grant cycle of requester 2 clears outputs and restarts at ptr=7.
    task automatic test_reset_mid_slot();
        do_reset();
        req = 8'h14; enable = 1'b1;
        tick();
        checks++; if (grant !== 8'h04) begin errors++; $display("[TB] FAIL mid_c1: got %h expected 04", grant); end
        tick();
        checks++; if (grant !== 8'h04) begin errors++; $display("[TB] FAIL mid_c2: got %h expected 04", grant); end
        rst = 1'b0; release_i = 1'b1;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_grant: got %h expected 00", grant); end
        checks++; if (sel !== 3'd0) begin errors++; $display("[TB] FAIL mid_rst_sel: got %0d expected 0", sel); end
        checks++; if (sel_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", sel_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_busy: got %b expected 0", busy); end
        rst = 1'b1; release_i = 1'b0;
        tick();
        checks++; if (grant !== 8'h04) begin errors++; $display("[TB] FAIL mid_regrant: got %h expected 04", grant); end
        checks++; if (sel !== 3'd2) begin errors++; $display("[TB] FAIL mid_regrant_sel: got %0d expected 2", sel); end
    endtask

    // Release coinciding with timeout ends the slot once; the pointer advances by one.
    task automatic test_release_at_end();
        do_reset();
        req = 8'hFF; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (grant !== 8'h01) begin errors++; $display("[TB] FAIL endrel_hold i=%0d: got %h expected 01", i, grant); end
        end
        release_i = 1'b1;
        tick();
        checks++; if (grant !== 8'h00) begin errors++; $display("[TB] FAIL endrel_gap: got %h expected 00", grant); end
        release_i = 1'b0;
        tick();
        checks++; if (grant !== 8'h02) begin errors++; $display("[TB] FAIL endrel_next: got %h expected 02", grant); end
        checks++; if (sel !== 3'd1) begin errors++; $display("[TB] FAIL endrel_next_sel: got %0d expected 1", sel); end
    endtask

    // HOLD_CYCLES=1 instance: 1 granted cycle then 1 idle cycle.
    task automatic test_hold_one();
        logic [7:0] exp_g;
        do_reset();
        req = 8'h08; enable = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            exp_g = ((c % 2) == 0) ? 8'h08 : 8'h00;
            checks++; if (grant1 !== exp_g) begin errors++; $display("[TB] FAIL hold1_grant c=%0d: got %h expected %h", c, grant1, exp_g); end
            checks++; if (busy1 !== exp_g[3]) begin errors++; $display("[TB] FAIL hold1_busy c=%0d: got %b expected %b", c, busy1, exp_g[3]); end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b0; enable = 1'b0; req = 8'h00; release_i = 1'b0;
        $display("[TB] starting rr_grant_ctrl bench");
        test_reset();
        test_single();
        test_full_load();
        test_early_release();
        test_fairness();
        test_reset_mid_slot();
        test_release_at_end();
        test_hold_one();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
